alu_arbiter: RTL and testbench

Sequencer and two-way arbiter that shares the single 16-bit `alu` instance between two requesters (requester 0: pipeline execute stage; requester 1: auxiliary/microcode engine). It accepts a request, latches operands and op, drives the ALU for one `execute` cycle, waits a configurable latency, captures result and flags, and returns them to the winning requester with a one-cycle ack.

---
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-way round-robin arbiter and sequencer that shares one
// 16-bit ALU between the execute stage (requester 0) and the auxiliary /
// microcode engine (requester 1). A granted request has its operands
// latched, gets one execute strobe, waits ALU_LATENCY cycles, has its
// result and flags captured, and receives a one-cycle ack.
//
// Optional feature macro: ALU_ARB_FLAG_SHADOW_EN
//   defined     -> one {C,Z,S,V} flag register per requester; a capture only
//                  updates the register of the granted requester.
//   not defined -> one shared flag register driven onto flags0 and flags1.
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [4:0]  op0,
  input  logic [4:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] result,
  output logic [3:0]  flags0,
  output logic [3:0]  flags1,
  output logic        busy,
  output logic        gnt_id,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_execute,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_s,
  input  logic        alu_v
);

  // Latency is kept inside the 3-bit wait counter's useful range 1..7.
  localparam int LAT_CLAMP = (ALU_LATENCY < 1) ? 1 :
                             ((ALU_LATENCY > 7) ? 7 : ALU_LATENCY);
  localparam logic [2:0] LAT = 3'(LAT_CLAMP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [4:0]  op_reg;
  logic        gnt_reg;
  logic        last_reg;
  logic [1:0]  ack_reg;
  logic        busy_reg;
  logic        exec_reg;
  logic [15:0] result_reg;

  // Per-requester views of the request ports, indexable by requester id.
  logic [1:0]  req_vec;
  logic [15:0] a_vec  [2];
  logic [15:0] b_vec  [2];
  logic [4:0]  op_vec [2];

  logic [1:0]  elig_next;
  logic        grant_next;
  logic        win_next;
  logic        capture_next;
  logic [3:0]  alu_flags;

  assign req_vec   = {req1, req0};
  assign a_vec[0]  = a0;
  assign a_vec[1]  = a1;
  assign b_vec[0]  = b0;
  assign b_vec[1]  = b1;
  assign op_vec[0] = op0;
  assign op_vec[1] = op1;
  assign alu_flags = {alu_c, alu_z, alu_s, alu_v};

  // A requester just acked in DONE still holds req high for that cycle, so
  // it must not be seen as a new request until the following cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign elig_next[gi] = req_vec[gi] &&
                           !((state_reg == DONE) && (gnt_reg == 1'(gi)));
  end

  // Round-robin choice: a lone eligible requester wins, a tie goes to the
  // requester that was not served last.
  always_comb begin
    grant_next = |elig_next;
    if (&elig_next) begin
      win_next = ~last_reg;
    end else begin
      win_next = elig_next[1];
    end
  end

  // Result and flags are sampled on the edge that ends the last wait cycle.
  assign capture_next = (state_reg == WAIT) && (cnt_reg == 3'd1);

  // Sequencer: grant, issue, wait out the ALU latency, capture, ack.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      op_reg     <= 5'd0;
      gnt_reg    <= 1'b0;
      last_reg   <= 1'b1;
      ack_reg    <= 2'b00;
      busy_reg   <= 1'b0;
      exec_reg   <= 1'b0;
      result_reg <= 16'h0000;
    end else begin
      ack_reg  <= 2'b00;
      exec_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (grant_next) begin
            a_reg     <= a_vec[win_next];
            b_reg     <= b_vec[win_next];
            op_reg    <= op_vec[win_next];
            gnt_reg   <= win_next;
            last_reg  <= win_next;
            exec_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          cnt_reg   <= LAT;
          busy_reg  <= 1'b1;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (capture_next) begin
            result_reg       <= alu_out;
            ack_reg[gnt_reg] <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_FLAG_SHADOW_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_flags
    logic [3:0] flags_reg;
    // Each requester keeps its own flags; only the owner of the op updates.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        flags_reg <= 4'h0;
      end else if (capture_next && (gnt_reg == 1'(gi))) begin
        flags_reg <= alu_flags;
      end
    end
  end
  assign flags0 = g_flags[0].flags_reg;
  assign flags1 = g_flags[1].flags_reg;
`else
  logic [3:0] flags_reg;
  // One shared flag register, refreshed by every capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_reg <= 4'h0;
    end else if (capture_next) begin
      flags_reg <= alu_flags;
    end
  end
  assign flags0 = flags_reg;
  assign flags1 = flags_reg;
`endif

  assign ack0        = ack_reg[0];
  assign ack1        = ack_reg[1];
  assign result      = result_reg;
  assign busy        = busy_reg;
  assign gnt_id      = gnt_reg;
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_op      = op_reg;
  assign alu_execute = exec_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: checks alu_arbiter against a transaction-level model.
// Two instances: latency 1 (directed + random traffic) and latency 3.
// The ALU is modelled here; its output is garbage except in the one cycle
// where a correctly timed capture should sample it.
module tb_alu_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // latency-1 instance
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [4:0]  op0, op1;
  logic        ack0, ack1, busy, gnt_id, alu_execute;
  logic [15:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  flags0, flags1;
  logic [4:0]  alu_op;
  logic        alu_c, alu_z, alu_s, alu_v;

  // latency-3 instance
  logic        d3_req0, d3_req1;
  logic [15:0] d3_a0, d3_b0, d3_a1, d3_b1;
  logic [4:0]  d3_op0, d3_op1;
  logic        d3_ack0, d3_ack1, d3_busy, d3_gnt_id, d3_alu_execute;
  logic [15:0] d3_result, d3_alu_a, d3_alu_b, d3_alu_out;
  logic [3:0]  d3_flags0, d3_flags1;
  logic [4:0]  d3_alu_op;
  logic        d3_alu_c, d3_alu_z, d3_alu_s, d3_alu_v;

  alu_arbiter #(.ALU_LATENCY(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1), .ack0(ack0), .ack1(ack1), .result(result),
    .flags0(flags0), .flags1(flags1), .busy(busy), .gnt_id(gnt_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_execute(alu_execute),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s), .alu_v(alu_v)
  );

  alu_arbiter #(.ALU_LATENCY(LAT3)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .req0(d3_req0), .req1(d3_req1), .a0(d3_a0), .b0(d3_b0), .a1(d3_a1), .b1(d3_b1),
    .op0(d3_op0), .op1(d3_op1), .ack0(d3_ack0), .ack1(d3_ack1), .result(d3_result),
    .flags0(d3_flags0), .flags1(d3_flags1), .busy(d3_busy), .gnt_id(d3_gnt_id),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op), .alu_execute(d3_alu_execute),
    .alu_out(d3_alu_out), .alu_c(d3_alu_c), .alu_z(d3_alu_z), .alu_s(d3_alu_s), .alu_v(d3_alu_v)
  );

  // Reference ALU: returns {C,Z,S,V,result}.
  function automatic logic [19:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    s = 17'h0; c = 1'b0; v = 1'b0;
    case (op)
      5'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      5'd2: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
                  v = (a[15] != b[15]) && (r[15] != a[15]); end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      default: r = a;
    endcase
    return {c, (r == 16'h0), r[15], v, r};
  endfunction

  // External ALUs with fixed latency after the execute strobe.
  logic [20:0] pipe1;
  logic [20:0] pipe3 [3];
  always @(posedge CLK) begin
    pipe1    <= alu_execute ? {1'b1, alu_ref(alu_a, alu_b, alu_op)} : 21'h0;
    pipe3[0] <= d3_alu_execute ? {1'b1, alu_ref(d3_alu_a, d3_alu_b, d3_alu_op)} : 21'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign alu_out = pipe1[20] ? pipe1[15:0] : 16'hDEAD;
  assign {alu_c, alu_z, alu_s, alu_v} = pipe1[20] ? pipe1[19:16] : 4'hF;
  assign d3_alu_out = pipe3[2][20] ? pipe3[2][15:0] : 16'hDEAD;
  assign {d3_alu_c, d3_alu_z, d3_alu_s, d3_alu_v} = pipe3[2][20] ? pipe3[2][19:16] : 4'hF;

  // Transaction model: grant cycle, ack cycle, operands and expected values.
  int          n_checks, n_fail, cyc;
  int          m_last, m_gid, m_g, m_ack_cyc, m_next;
  logic [15:0] m_a, m_b;
  logic [4:0]  m_op;
  logic [19:0] m_val;
  logic [15:0] m_result;
  logic [3:0]  m_flags [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_last = 1; m_gid = 0; m_g = -100; m_ack_cyc = -100; m_next = 0;
    m_a = 16'h0; m_b = 16'h0; m_op = 5'd0; m_val = 20'h0; m_result = 16'h0;
    m_flags[0] = 4'h0; m_flags[1] = 4'h0;
  endtask

  // Model decides on the current inputs, then one clock, then compare.
  task automatic tick();
    logic e0, e1;
    int   w;
    if (cyc >= m_next) begin
      e0 = req0 && !(cyc == m_ack_cyc && m_gid == 0);
      e1 = req1 && !(cyc == m_ack_cyc && m_gid == 1);
      if (e0 || e1) begin
        if (e0 && e1) w = 1 - m_last;
        else          w = e1 ? 1 : 0;
        m_last = w; m_gid = w; m_g = cyc;
        m_ack_cyc = cyc + LAT + 2; m_next = m_ack_cyc;
        m_a  = (w != 0) ? a1 : a0;
        m_b  = (w != 0) ? b1 : b0;
        m_op = (w != 0) ? op1 : op0;
        m_val = alu_ref(m_a, m_b, m_op);
      end
    end
    @(posedge CLK); #1; cyc++;
    if (cyc == m_ack_cyc) begin
      m_result = m_val[15:0];
`ifdef ALU_ARB_FLAG_SHADOW_EN
      m_flags[m_gid] = m_val[19:16];
`else
      m_flags[0] = m_val[19:16];
      m_flags[1] = m_val[19:16];
`endif
      $display("cycle %0d: req%0d op=%0d a=%h b=%h -> result=%h flags0=%b flags1=%b",
               cyc, m_gid, m_op, m_a, m_b, result, flags0, flags1);
    end
    check("ack0",   32'(ack0),        32'(cyc == m_ack_cyc && m_gid == 0));
    check("ack1",   32'(ack1),        32'(cyc == m_ack_cyc && m_gid == 1));
    check("busy",   32'(busy),        32'(cyc > m_g && cyc <= m_g + LAT + 1));
    check("exec",   32'(alu_execute), 32'(cyc == m_g + 1));
    check("gnt_id", 32'(gnt_id),      m_gid);
    check("alu_a",  32'(alu_a),       32'(m_a));
    check("alu_op", 32'(alu_op),      32'(m_op));
    check("result", 32'(result),      32'(m_result));
    check("flags0", 32'(flags0),      32'(m_flags[0]));
    check("flags1", 32'(flags1),      32'(m_flags[1]));
  endtask

  // Present one request, run until its ack (bounded), drop it; lat = -1 on timeout.
  task automatic run_one(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] op, output int lat);
    int t0;
    lat = -1;
    if (id == 0) begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    else         begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        lat = cyc - t0;
        break;
      end
    end
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h7FFF;
      1: v = 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, t_ack0, t_ack1, n0, n1, at3, bc3, ec3, ex_at3, a1c3;
    n_checks = 0; n_fail = 0;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
    d3_req0 = 0; d3_req1 = 0; d3_a0 = 0; d3_b0 = 0; d3_a1 = 0; d3_b1 = 0;
    d3_op0 = 0; d3_op1 = 0;
    model_reset();

    // reset values
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ack0",   32'(ack0), 0);
    check("rst_ack1",   32'(ack1), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_exec",   32'(alu_execute), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags0", 32'(flags0), 0);
    check("rst_flags1", 32'(flags1), 0);
    check("rst_gnt",    32'(gnt_id), 0);
    check("rst_alu_a",  32'(alu_a), 0);
    check("rst_busy3",  32'(d3_busy), 0);
    RST = 1'b0;
    model_reset();

    // tie from reset: req0 first, then strict alternation while both held
    req0 = 1; a0 = 16'h1234; b0 = 16'h0101; op0 = 5'd1;
    req1 = 1; a1 = 16'h0010; b1 = 16'h0020; op1 = 5'd2;
    t0 = cyc; t_ack0 = -1; t_ack1 = -1; n0 = 0; n1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack0) begin n0++; if (t_ack0 < 0) t_ack0 = cyc - t0; end
      if (ack1) begin n1++; if (t_ack1 < 0) t_ack1 = cyc - t0; end
    end
    req0 = 0; req1 = 0;
    check("tie_ack0_cycle", t_ack0, 3);
    check("tie_ack1_cycle", t_ack1, 6);
    check("tie_n_ack0", n0, 2);
    check("tie_n_ack1", n1, 2);

    // single add
    run_one(0, 16'h0005, 16'hFFF9, 5'd1, lat);
    check("add_latency", lat, 3);
    check("add_result", 32'(result), 32'h0000FFFE);
    check("add_flags0", 32'(flags0), 32'b0010);

    // signed overflow on requester 1
    run_one(1, 16'h7FFF, 16'h7FFF, 5'd1, lat);
    check("ovf_latency", lat, 3);
    check("ovf_result", 32'(result), 32'h0000FFFE);
    check("ovf_flags1", 32'(flags1), 32'b0011);

    // flag shadowing
    run_one(0, 16'h7FFF, 16'h7FFF, 5'd1, lat);
    check("shadow_first_v0", 32'(flags0[0]), 1);
    run_one(1, 16'h0001, 16'h0001, 5'd1, lat);
    check("shadow_result", 32'(result), 32'h2);
    check("shadow_flags1", 32'(flags1), 32'b0000);
`ifdef ALU_ARB_FLAG_SHADOW_EN
    check("shadow_flags0_v", 32'(flags0[0]), 1);
`else
    check("shadow_flags0_v", 32'(flags0[0]), 0);
`endif

    // asynchronous reset during WAIT, then a clean re-request
    tick();
    req1 = 1; a1 = 16'h00F0; b1 = 16'h0F00; op1 = 5'd4;
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    RST = 1'b1;
    #1;
    check("midrst_ack1",   32'(ack1), 0);
    check("midrst_busy",   32'(busy), 0);
    check("midrst_exec",   32'(alu_execute), 0);
    check("midrst_gnt",    32'(gnt_id), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_flags0", 32'(flags0), 0);
    check("midrst_alu_a",  32'(alu_a), 0);
    req1 = 0;
    @(posedge CLK);
    #1;
    check("midrst_no_ack", 32'(ack1), 0);
    RST = 1'b0;
    model_reset();
    run_one(1, 16'h00F0, 16'h0F00, 5'd4, lat);
    check("rerequest_latency", lat, 3);
    check("rerequest_result", 32'(result), 32'h0FF0);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      if (ack0 || !req0) begin
        if ($urandom_range(0, 99) < 60) begin
          req0 = 1; a0 = rand_operand(); b0 = rand_operand(); op0 = 5'($urandom_range(0, 7));
        end else req0 = 0;
      end
      if (ack1 || !req1) begin
        if ($urandom_range(0, 99) < 60) begin
          req1 = 1; a1 = rand_operand(); b1 = rand_operand(); op1 = 5'($urandom_range(0, 7));
        end else req1 = 0;
      end
      tick();
    end
    req0 = 0; req1 = 0;

    // latency-3 instance: single request
    d3_req0 = 1; d3_a0 = 16'h0005; d3_b0 = 16'hFFF9; d3_op0 = 5'd1;
    at3 = -1; bc3 = 0; ec3 = 0; ex_at3 = -1; a1c3 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK); #1;
      if (d3_busy) bc3++;
      if (d3_alu_execute) begin ec3++; ex_at3 = k; end
      if (d3_ack1) a1c3++;
      if (d3_ack0 && at3 < 0) begin at3 = k; d3_req0 = 0; end
    end
    check("lat3_ack_cycle",  at3, 5);
    check("lat3_busy_count", bc3, 4);
    check("lat3_exec_count", ec3, 1);
    check("lat3_exec_cycle", ex_at3, 1);
    check("lat3_ack1_count", a1c3, 0);
    check("lat3_result", 32'(d3_result), 32'h0000FFFE);
    check("lat3_flags0", 32'(d3_flags0), 32'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
